// File: rtl/lampFPU_pkg.sv
// Shared lampFPU types and constants.
// Float format, round-bit positions and special encodings.
package lampFPU_pkg;

  localparam int LAMP_FLOAT_E_DW = 8;
  localparam int LAMP_FLOAT_F_DW = 7;
  localparam int LAMP_FLOAT_DW   = 1 + LAMP_FLOAT_E_DW + LAMP_FLOAT_F_DW;

  // Positions inside the pre-round mantissa {01, frac, G, R, S}
  localparam int LAMP_ROUND_S_IDX = 0;
  localparam int LAMP_ROUND_R_IDX = 1;
  localparam int LAMP_ROUND_G_IDX = 2;
  localparam int LAMP_FRAC_LSB    = 3;
  localparam int LAMP_FRAC_MSB    = LAMP_FRAC_LSB + LAMP_FLOAT_F_DW - 1;

  localparam logic [LAMP_FLOAT_E_DW-1:0] LAMP_INF_E  = '1;
  localparam logic [LAMP_FLOAT_F_DW-1:0] LAMP_INF_F  = '0;
  localparam logic [LAMP_FLOAT_E_DW-1:0] LAMP_ZERO_E = '0;
  localparam logic [LAMP_FLOAT_F_DW-1:0] LAMP_ZERO_F = '0;

  // Sticky flag bit positions in {OF, UF, NX}
  localparam int LAMP_FLAG_NX = 0;
  localparam int LAMP_FLAG_UF = 1;
  localparam int LAMP_FLAG_OF = 2;

  typedef struct packed {
    logic                       s;
    logic [LAMP_FLOAT_E_DW-1:0] e;
    logic [LAMP_FLOAT_F_DW-1:0] f;
  } lamp_float_t;

  // Bundle carried from the round stage to the pack stage
  typedef struct packed {
    logic                       s;
    logic [LAMP_FLOAT_E_DW-1:0] e;
    logic [LAMP_FLOAT_F_DW-1:0] f;
    logic                       carry;
    logic                       nx;
    logic                       rnd;
    logic                       of;
    logic                       uf;
  } lamp_s1_t;

endpackage

// File: rtl/lampfpu_rne_incr.sv
// Round-to-nearest-even increment on the fraction field.
// Produces the rounded fraction, its carry-out and inexactness.
module lampfpu_rne_incr
  import lampFPU_pkg::*;
(
  input  logic [LAMP_FLOAT_F_DW-1:0] frac_i,
  input  logic                       g_i,
  input  logic                       r_i,
  input  logic                       s_i,
  output logic [LAMP_FLOAT_F_DW-1:0] frac_o,
  output logic                       carry_o,
  output logic                       inexact_o
);

  logic incr;

  // Ties go to the even fraction, so the LSB breaks a pure halfway case
  assign incr = g_i & (r_i | s_i | frac_i[0]);

  assign {carry_o, frac_o} = {1'b0, frac_i}
                           + {{LAMP_FLOAT_F_DW{1'b0}}, incr};

  assign inexact_o = g_i | r_i | s_i;

endmodule

// File: rtl/lampfpu_sqrt_round.sv
// Two-stage RNE rounding and packing for the sqrt unit.
// S1 rounds the mantissa; S2 adjusts exponent, overrides, packs.
module lampfpu_sqrt_round
  import lampFPU_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         valid_i,
  output logic                         ready_o,
  input  logic                         s_i,
  input  logic [LAMP_FLOAT_E_DW-1:0]   e_i,
  input  logic [LAMP_FLOAT_F_DW+4:0]   f_i,
  input  logic                         isToRound_i,
  input  logic                         isOverflow_i,
  input  logic                         isUnderflow_i,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic [LAMP_FLOAT_DW-1:0]     res_o,
  output logic [2:0]                   flags_o,
  input  logic                         flags_clr_i
);

  logic                       s1_valid_q;
  lamp_s1_t                   s1_q;
  lamp_s1_t                   s1_d;
  logic                       s2_valid_q;
  lamp_float_t                res_q;
  lamp_float_t                res_d;
  logic [2:0]                 s2_fl_q;
  logic [2:0]                 s2_fl_d;
  logic [2:0]                 flags_q;
  logic [2:0]                 flags_d;

  logic                       s1_load;
  logic                       s2_load;
  logic                       out_xfer;

  logic [LAMP_FLOAT_F_DW-1:0] rnd_frac;
  logic                       rnd_carry;
  logic                       rnd_nx;

  logic [LAMP_FLOAT_E_DW-1:0] e_adj;
  logic                       e_cy;
  logic                       of;
  logic                       uf;
  logic                       nx;

  assign s2_load  = ~s2_valid_q | ready_i;
  assign s1_load  = ~s1_valid_q | s2_load;
  assign ready_o  = s1_load;
  assign out_xfer = s2_valid_q & ready_i;

  lampfpu_rne_incr u_rne (
    .frac_i    (f_i[LAMP_FRAC_MSB:LAMP_FRAC_LSB]),
    .g_i       (f_i[LAMP_ROUND_G_IDX]),
    .r_i       (f_i[LAMP_ROUND_R_IDX]),
    .s_i       (f_i[LAMP_ROUND_S_IDX]),
    .frac_o    (rnd_frac),
    .carry_o   (rnd_carry),
    .inexact_o (rnd_nx)
  );

  // S1 next state: rounded fields, or raw fields for specials
  always_comb begin
    s1_d       = '0;
    s1_d.s     = s_i;
    s1_d.e     = e_i;
    s1_d.rnd   = isToRound_i;
    if (isToRound_i) begin
      s1_d.f     = rnd_frac;
      s1_d.carry = rnd_carry;
      s1_d.nx    = rnd_nx;
      s1_d.of    = isOverflow_i;
      s1_d.uf    = isUnderflow_i;
    end else begin
      s1_d.f     = f_i[LAMP_FRAC_MSB:LAMP_FRAC_LSB];
    end
  end

  // S2 next state: exponent adjust, exception override, pack
  always_comb begin
    {e_cy, e_adj} = {1'b0, s1_q.e}
                  + {{LAMP_FLOAT_E_DW{1'b0}}, s1_q.carry};
    of = s1_q.of | (s1_q.rnd & (e_cy | (&e_adj)));
    uf = s1_q.uf & ~of;
    nx = s1_q.nx | of | uf;
    res_d   = '0;
    res_d.s = s1_q.s;
    unique case (1'b1)
      of: begin
        res_d.e = LAMP_INF_E;
        res_d.f = LAMP_INF_F;
      end
      uf: begin
        res_d.e = LAMP_ZERO_E;
        res_d.f = LAMP_ZERO_F;
      end
      default: begin
        res_d.e = e_adj;
        res_d.f = s1_q.f;
      end
    endcase
    s2_fl_d               = '0;
    s2_fl_d[LAMP_FLAG_OF] = of;
    s2_fl_d[LAMP_FLAG_UF] = uf;
    s2_fl_d[LAMP_FLAG_NX] = nx;
  end

  // Sticky flags: clear first, then OR in the leaving result
  always_comb begin
    flags_d = flags_clr_i ? 3'b000 : flags_q;
    if (out_xfer) begin
      flags_d = flags_d | s2_fl_q;
    end
  end

  // Stage 1 register
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
    end else if (s1_load) begin
      s1_valid_q <= valid_i;
      if (valid_i) begin
        s1_q <= s1_d;
      end
    end
  end

  // Stage 2 register, holds while the consumer stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      res_q      <= '0;
      s2_fl_q    <= '0;
    end else if (s2_load) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        res_q   <= res_d;
        s2_fl_q <= s2_fl_d;
      end
    end
  end

  // Sticky flag register
  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q <= '0;
    end else begin
      flags_q <= flags_d;
    end
  end

  assign valid_o = s2_valid_q;
  assign res_o   = res_q;
  assign flags_o = flags_q;

endmodule

// File: tb/tb_lampfpu_sqrt_round.sv
// Bench for lampfpu_sqrt_round: directed corners plus random
// traffic, scoreboard of expected {flags, result} pairs.
module tb_lampfpu_sqrt_round;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic        ready_o;
  logic        s_i;
  logic [7:0]  e_i;
  logic [11:0] f_i;
  logic        isToRound_i;
  logic        isOverflow_i;
  logic        isUnderflow_i;
  logic        valid_o;
  logic        ready_i;
  logic [15:0] res_o;
  logic [2:0]  flags_o;
  logic        flags_clr_i;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [18:0] sb[$];
  logic [2:0]  exp_fl;
  logic        prev_stall;
  logic [15:0] prev_res;
  bit          rand_rdy = 1'b0;

  lampfpu_sqrt_round dut (
    .clk           (clk),
    .rst           (rst),
    .valid_i       (valid_i),
    .ready_o       (ready_o),
    .s_i           (s_i),
    .e_i           (e_i),
    .f_i           (f_i),
    .isToRound_i   (isToRound_i),
    .isOverflow_i  (isOverflow_i),
    .isUnderflow_i (isUnderflow_i),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .res_o         (res_o),
    .flags_o       (flags_o),
    .flags_clr_i   (flags_clr_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, expv,
               $time);
    end
  endtask

  // Reference: value-level RNE on the 9-bit significand {01,frac}
  function automatic logic [18:0] ref_model(
    input logic s, input logic [7:0] e, input logic [11:0] f,
    input logic tr, input logic ov, input logic un);
    int keep, rem, ex, fr;
    logic o, u, x;
    logic [15:0] r;
    if (!tr) return {3'b000, s, e, f[9:3]};
    keep = int'(f) / 8;
    rem  = int'(f) % 8;
    if (rem > 4 || (rem == 4 && keep % 2 == 1)) keep++;
    ex = int'(e);
    if (keep == 256) begin
      ex++;
      fr = 0;
    end else begin
      fr = keep - 128;
    end
    o = ov || ex >= 255;
    u = !o && un;
    x = rem != 0 || o || u;
    if (o) r = {s, 8'hFF, 7'h00};
    else if (u) r = {s, 15'h0000};
    else r = {s, 8'(ex), 7'(fr)};
    return {o, u, x, r};
  endfunction

  // Present one input and wait (bounded) for its transfer
  task automatic send(input logic s, input logic [7:0] e,
                      input logic [11:0] f, input logic tr,
                      input logic ov, input logic un,
                      input logic [18:0] expv);
    bit ok = 1'b0;
    valid_i = 1'b1; s_i = s; e_i = e; f_i = f;
    isToRound_i = tr; isOverflow_i = ov; isUnderflow_i = un;
    for (int n = 0; n < 300 && !ok; n++) begin
      @(negedge clk);
      if (ready_o) ok = 1'b1;
    end
    if (ok) begin
      sb.push_back(expv);
    end else begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: ready_o stuck at 0");
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    valid_i = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic clr_flags();
    flags_clr_i = 1'b1;
    @(posedge clk); #1;
    flags_clr_i = 1'b0;
  endtask

  // Random consumer back-pressure
  initial forever begin
    @(posedge clk); #1;
    if (rand_rdy) ready_i = ($urandom_range(0, 3) != 0);
  end

  // Monitor: pop and compare on every output transfer
  initial forever begin
    @(negedge clk);
    if (rst) begin
      sb.delete();
      exp_fl = 3'b000;
      prev_stall = 1'b0;
    end else begin
      logic [2:0] nxt;
      logic [18:0] e;
      chk("flags", {29'd0, flags_o}, {29'd0, exp_fl});
      if (prev_stall) begin
        chk("stall_valid", {31'd0, valid_o}, 32'd1);
        chk("stall_res", {16'd0, res_o}, {16'd0, prev_res});
      end
      nxt = flags_clr_i ? 3'b000 : exp_fl;
      if (valid_o && ready_i) begin
        if (sb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_output: res %h with none expected",
                   res_o);
        end else begin
          e = sb.pop_front();
          chk("res", {16'd0, res_o}, {16'd0, e[15:0]});
          nxt = nxt | e[18:16];
        end
      end
      exp_fl = nxt;
      prev_stall = valid_o && !ready_i;
      prev_res = res_o;
    end
  end

  initial begin
    logic [18:0] m;
    logic [31:0] rv;
    logic [7:0]  re;
    logic [11:0] rf;
    logic        rs, rt, ro, ru;
    bit          done;
    rst = 1'b1; valid_i = 1'b0; ready_i = 1'b1; flags_clr_i = 1'b0;
    s_i = 1'b0; e_i = '0; f_i = '0;
    isToRound_i = 1'b0; isOverflow_i = 1'b0; isUnderflow_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_valid_o", {31'd0, valid_o}, 32'd0);
    chk("rst_ready_o", {31'd0, ready_o}, 32'd1);
    chk("rst_res_o", {16'd0, res_o}, 32'd0);
    chk("rst_flags_o", {29'd0, flags_o}, 32'd0);
    @(posedge clk); #1;

    // Mantissa overflow into exponent, with 2-cycle latency check
    send(1'b0, 8'h7F, {2'b01, 7'h7F, 3'b100}, 1'b1, 1'b0, 1'b0,
         {3'b001, 16'h4000});
    valid_i = 1'b0;
    @(negedge clk);
    chk("lat_cycle1", {31'd0, valid_o}, 32'd0);
    @(negedge clk);
    chk("lat_cycle2", {31'd0, valid_o}, 32'd1);
    @(posedge clk); #1;
    idle(3);
    clr_flags();

    // Tie to even, then tie broken by R
    send(1'b0, 8'h7F, {2'b01, 7'h00, 3'b100}, 1'b1, 1'b0, 1'b0,
         {3'b001, 16'h3F80});
    send(1'b0, 8'h7F, {2'b01, 7'h00, 3'b110}, 1'b1, 1'b0, 1'b0,
         {3'b001, 16'h3F81});
    idle(4);
    clr_flags();

    // Exponent rounds up into infinity
    send(1'b0, 8'hFE, {2'b01, 7'h7F, 3'b110}, 1'b1, 1'b0, 1'b0,
         {3'b101, 16'h7F80});
    idle(4);
    clr_flags();

    // Producer underflow, negative sign
    send(1'b1, 8'h01, {2'b01, 7'h00, 3'b000}, 1'b1, 1'b0, 1'b1,
         {3'b011, 16'h8000});
    idle(4);
    clr_flags();

    // Overflow beats underflow
    send(1'b0, 8'h40, {2'b01, 7'h12, 3'b000}, 1'b1, 1'b1, 1'b1,
         {3'b101, 16'h7F80});
    idle(4);
    clr_flags();

    // Special value passes through, flags untouched
    send(1'b0, 8'hFF, {2'b01, 7'h40, 3'b000}, 1'b0, 1'b0, 1'b0,
         {3'b000, 16'h7FC0});
    idle(4);

    // Back-pressure: two accepted, third refused, ordered drain
    ready_i = 1'b0;
    send(1'b0, 8'h10, {2'b01, 7'h01, 3'b000}, 1'b1, 1'b0, 1'b0,
         {3'b000, 16'h0801});
    send(1'b1, 8'h20, {2'b01, 7'h02, 3'b000}, 1'b1, 1'b0, 1'b0,
         {3'b000, 16'h9002});
    s_i = 1'b0; e_i = 8'h30; f_i = {2'b01, 7'h03, 3'b000};
    isToRound_i = 1'b1; isOverflow_i = 1'b0; isUnderflow_i = 1'b0;
    valid_i = 1'b1;
    @(negedge clk);
    chk("bp_ready_low", {31'd0, ready_o}, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    ready_i = 1'b1;
    send(1'b0, 8'h30, {2'b01, 7'h03, 3'b000}, 1'b1, 1'b0, 1'b0,
         {3'b000, 16'h1803});
    idle(5);

    // Reset with both stages full
    ready_i = 1'b0;
    send(1'b0, 8'h7F, {2'b01, 7'h55, 3'b111}, 1'b1, 1'b0, 1'b0,
         {3'b001, 16'h3FD6});
    send(1'b0, 8'h7F, {2'b01, 7'h2A, 3'b101}, 1'b1, 1'b0, 1'b0,
         {3'b001, 16'h3FAB});
    valid_i = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid_o", {31'd0, valid_o}, 32'd0);
    chk("mid_rst_flags_o", {29'd0, flags_o}, 32'd0);
    chk("mid_rst_res_o", {16'd0, res_o}, 32'd0);
    @(posedge clk); #1;
    ready_i = 1'b1;
    idle(6);

    // Random traffic under random back-pressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 400; i++) begin
      rv = $urandom;
      rs = rv[0];
      rt = ($urandom_range(0, 7) != 0);
      ro = ($urandom_range(0, 15) == 0);
      ru = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 7))
        0: re = 8'hFE;
        1: re = 8'hFF;
        2: re = 8'h00;
        default: re = rv[15:8];
      endcase
      rf = {2'b01, rv[25:16]};
      if ($urandom_range(0, 5) == 0) rf = {2'b01, 7'h7F, rv[28:26]};
      flags_clr_i = ($urandom_range(0, 15) == 0);
      m = ref_model(rs, re, rf, rt, ro, ru);
      send(rs, re, rf, rt, ro, ru, m);
      if ($urandom_range(0, 7) == 0) begin
        valid_i = 1'b0;
        @(posedge clk); #1;
      end
    end
    valid_i = 1'b0;
    flags_clr_i = 1'b0;
    rand_rdy = 1'b0;
    ready_i = 1'b1;

    done = 1'b0;
    for (int n = 0; n < 200 && !done; n++) begin
      @(posedge clk); #1;
      if (sb.size() == 0) done = 1'b1;
    end
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout: %0d results outstanding", sb.size());
    end
    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
